// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Purely declarative: no logic and no latency of its own.
// Has no handshake; users import the op and state encodings.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_ITERS = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      ZERO = 2'b11
   } state_e;

endpackage

// File: rtl/red_nor.sv
// Reduction NOR: flags an all-zero input word.
// Purely combinational, zero cycles.
// Has no handshake.
module red_nor #(
   parameter int W = 32
) (
   input  logic [W-1:0] d_i,
   output logic         z_o
);

   assign z_o = ~|d_i;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO unit: MULT/MULTU/DIV/DIVU on a shared 32-step shift datapath.
// 33 edges from issue to HI/LO update; divide by zero finishes on the next edge.
// busy_out high while in flight; start/MTHI/MTLO are ignored until IDLE again.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int ITERS = MDU_ITERS
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [1:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             mthi_in,
   input  logic             mtlo_in,
   input  logic [WIDTH-1:0] wdata_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             div_zero_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

   state_e           state_q;
   logic [5:0]       cnt_q;
   logic             div_q;
   logic             neg_lo_q;   // product / quotient must be negated
   logic             neg_hi_q;   // remainder must be negated
   logic [WIDTH-1:0] opnd_q;     // |multiplicand| or |divisor|
   logic [WIDTH-1:0] acc_hi_q;   // product high half / partial remainder
   logic [WIDTH-1:0] acc_lo_q;   // multiplier bits / dividend -> quotient
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;
   logic             dz_q;

   logic             b_zero;
   logic             is_div;
   logic             is_signed;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_b;
   logic             add_cin;
   logic [WIDTH+1:0] sum;
   logic [WIDTH-1:0] acc_hi_d;
   logic [WIDTH-1:0] acc_lo_d;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0] hi_fix;
   logic [WIDTH-1:0] lo_fix;

   red_nor #(.W(WIDTH)) u_b_zero (
      .d_i (b_in),
      .z_o (b_zero)
   );

   // Issue-side decode: operation class and operand magnitudes.
   always_comb begin
      is_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
      is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
      a_abs     = (is_signed && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
      b_abs     = (is_signed && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;
   end

   // One iteration: shared adder does add-if-bit-set (mul) or trial subtract (div).
   always_comb begin
      if (div_q) begin
         add_a   = {acc_hi_q, acc_lo_q[WIDTH-1]};
         add_b   = ~{1'b0, opnd_q};
         add_cin = 1'b1;
      end else begin
         add_a   = {1'b0, acc_hi_q};
         add_b   = acc_lo_q[0] ? {1'b0, opnd_q} : '0;
         add_cin = 1'b0;
      end
      sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
      if (div_q) begin
         // Carry out of the subtract means the shifted remainder covered the divisor.
         acc_hi_d = sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
         acc_lo_d = {acc_lo_q[WIDTH-2:0], sum[WIDTH+1]};
      end else begin
         acc_hi_d = sum[WIDTH:1];
         acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Final sign correction of the magnitude result.
   always_comb begin
      prod_neg = ~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1);
      if (div_q) begin
         hi_fix = neg_hi_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
         lo_fix = neg_lo_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
      end else begin
         {hi_fix, lo_fix} = neg_lo_q ? prod_neg : {acc_hi_q, acc_lo_q};
      end
   end

   // Control FSM, datapath registers and HI/LO architectural state.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mthi_in) hi_q <= wdata_in;
               if (mtlo_in) lo_q <= wdata_in;
               if (start_in) begin
                  busy_q <= 1'b1;
                  cnt_q  <= '0;
                  div_q  <= is_div;
                  if (is_div && b_zero) begin
                     state_q <= ZERO;
                  end else begin
                     state_q  <= CALC;
                     neg_lo_q <= is_signed && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                     neg_hi_q <= is_signed && a_in[WIDTH-1];
                     opnd_q   <= is_div ? b_abs : a_abs;
                     acc_lo_q <= is_div ? a_abs : b_abs;
                     acc_hi_q <= '0;
                  end
               end
            end
            CALC: begin
               acc_hi_q <= acc_hi_d;
               acc_lo_q <= acc_lo_d;
               cnt_q    <= cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= hi_fix;
               lo_q    <= lo_fix;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            ZERO: begin
               done_q  <= 1'b1;
               dz_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_out     = busy_q;
   assign done_out     = done_q;
   assign div_zero_out = dz_q;
   assign hi_out       = hi_q;
   assign lo_out       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus hand-written corner sequences.
// Each operation is checked for latency, HI/LO values and status pulses.
// Every wait on done_out is bounded by a cycle budget.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   mul_div_unit dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .start_in     (start),
      .op_in        (op),
      .a_in         (a),
      .b_in         (b),
      .mthi_in      (mthi),
      .mtlo_in      (mtlo),
      .wdata_in     (wdata),
      .busy_out     (busy),
      .done_out     (done),
      .div_zero_out (dz),
      .hi_out       (hi),
      .lo_out       (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       nm;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] h, input logic [31:0] l);
      mthi = 1'b1; wdata = h; tick();
      mthi = 1'b0; mtlo = 1'b1; wdata = l; tick();
      mtlo = 1'b0;
   endtask

   // Returns the number of edges until done_out is seen, 0 if it never came.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
      int lat;
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
      chk({nm, " busy"}, {31'd0, busy}, 32'd1);
      wait_done(lat);
      chk({nm, " latency"}, lat, 32'd33);
      chk({nm, " hi"}, hi, eh);
      chk({nm, " lo"}, lo, el);
      chk({nm, " div_zero"}, {31'd0, dz}, 32'd0);
      chk({nm, " busy at done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      int ndone;

      vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max"};
      vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7"};
      vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
      vecs[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div ovf"};
      vecs[4] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        "divu 100/7"};
      vecs[5] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div 7/-2"};
      vecs[6] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         "multu 2^32"};
      vecs[7] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         "mult -1*-1"};
      vecs[8] = '{2'b10, 32'd3,         32'd5,         32'd3,         32'd0,         "divu 3/5"};
      vecs[9] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, "divu max/1"};

      // Reset state
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset div_zero", {31'd0, dz}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);

      // Table: issued back to back, each on the edge after the previous done
      for (int i = 0; i < 10; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].nm);

      // Divide by zero leaves HI/LO alone
      tick();
      preload(32'h11, 32'h22);
      chk("mt hi", hi, 32'h11);
      chk("mt lo", lo, 32'h22);
      start = 1'b1; op = 2'b10; a = 32'd5; b = 32'd0;
      tick();
      start = 1'b0;
      chk("dz edge0 busy", {31'd0, busy}, 32'd1);
      chk("dz edge0 done", {31'd0, done}, 32'd0);
      tick();
      chk("dz edge1 done", {31'd0, done}, 32'd1);
      chk("dz edge1 div_zero", {31'd0, dz}, 32'd1);
      chk("dz edge1 busy", {31'd0, busy}, 32'd0);
      chk("dz hi", hi, 32'h11);
      chk("dz lo", lo, 32'h22);
      tick();
      chk("dz done pulse", {31'd0, done}, 32'd0);
      chk("dz div_zero pulse", {31'd0, dz}, 32'd0);

      // Reset mid-flight aborts without a HI/LO write or done
      preload(32'h33, 32'h44);
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 9; i++) tick();
      rst = 1'b1;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("abort no done", ndone, 32'd0);
      run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "reissue divu");

      // MTHI on the issue edge writes, then the result overwrites it
      mthi = 1'b1; wdata = 32'h55;
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
      tick();
      start = 1'b0; mthi = 1'b0;
      chk("mthi+start hi", hi, 32'h55);
      chk("mthi+start lo", lo, 32'd14);
      wait_done(lat);
      chk("mthi+start latency", lat, 32'd33);
      chk("mthi+start result hi", hi, 32'd0);
      chk("mthi+start result lo", lo, 32'd6);

      // Start and MTHI/MTLO held while busy are ignored
      tick();
      preload(32'hAA, 32'hBB);
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 3) begin
            start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd0;
            mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD;
         end
      end
      chk("busy hold hi", hi, 32'hAA);
      chk("busy hold lo", lo, 32'hBB);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      wait_done(lat);
      chk("busy hold latency", lat, 32'd25);
      chk("busy hold div_zero", {31'd0, dz}, 32'd0);
      chk("busy hold result hi", hi, 32'd0);
      chk("busy hold result lo", lo, 32'd6);
      tick();
      chk("busy hold no requeue", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
